// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready register chain with bubble collapse, flush and optional stall counter
// Optional feature: define PIPE_REG_CHAIN_STALL_CNT_EN to enable the saturating downstream stall counter.
module pipe_reg_chain #(
    parameter int SIZE_DATA = 8,
    parameter int DEPTH     = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [SIZE_DATA-1:0]         i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [SIZE_DATA-1:0]         o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [15:0]                  o_stall_cnt
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [SIZE_DATA-1:0] data_q [DEPTH];
    logic [SIZE_DATA-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]     adv;
    logic [CW-1:0]        count_d;

    // a stage advances when downstream drains or any stage at or after it is empty
    always_comb begin
        adv = '0;
        for (int k = 0; k < DEPTH; k++) begin
            adv[k] = i_ready;
            for (int j = k; j < DEPTH; j++) begin
                if (!valid_q[j]) adv[k] = 1'b1;
            end
        end
    end

    // next stage contents: advancing stages take their predecessor, flush kills all valids but keeps data
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < DEPTH; k++) data_d[k] = data_q[k];
        valid_d[0] = adv[0] ? i_valid : valid_q[0];
        data_d[0]  = (!i_flush && adv[0] && i_valid) ? i_data : data_q[0];
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = adv[k] ? valid_q[k-1] : valid_q[k];
            data_d[k]  = (!i_flush && adv[k] && valid_q[k-1]) ? data_q[k-1] : data_q[k];
        end
        if (i_flush) valid_d = '0;
    end

    // stage registers; reset clears both valid and data
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < DEPTH; k++) data_q[k] <= data_d[k];
        end
    end

    // occupancy is a pure function of the registered valid bits
    always_comb begin
        count_d = '0;
        for (int k = 0; k < DEPTH; k++) count_d = count_d + CW'(valid_q[k]);
    end

    assign o_ready = !i_flush && adv[0];
    assign o_valid = valid_q[DEPTH-1];
    assign o_data  = data_q[DEPTH-1];
    assign o_count = count_d;

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // count cycles where output is offered but not taken, saturating; only reset clears it
    always_comb begin
        stall_d = (o_valid && !i_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    // stall counter register
    always_ff @(posedge i_clk) begin
        stall_q <= i_reset ? 16'd0 : stall_d;
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed checks of pipe_reg_chain at DEPTH 2, 3 and 4 sharing one stimulus stream
module tb_pipe_reg_chain;
    logic       i_clk = 1'b0;
    logic       i_reset, i_flush, i_valid, i_ready;
    logic [7:0] i_data;

    logic       rdy2, vld2, rdy3, vld3, rdy4, vld4;
    logic [7:0] dat2, dat3, dat4;
    logic [1:0] cnt2, cnt3;
    logic [2:0] cnt4;
    logic [15:0] st2, st3, st4;

    int vectors = 0;
    int errs    = 0;

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    localparam int STALL_EXP = 10;
`else
    localparam int STALL_EXP = 0;
`endif

    always #5 i_clk = ~i_clk;

    pipe_reg_chain #(.SIZE_DATA(8), .DEPTH(2)) u_d2 (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(rdy2),
        .i_data(i_data), .o_valid(vld2), .i_ready(i_ready), .o_data(dat2), .o_count(cnt2), .o_stall_cnt(st2));
    pipe_reg_chain #(.SIZE_DATA(8), .DEPTH(3)) u_d3 (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(rdy3),
        .i_data(i_data), .o_valid(vld3), .i_ready(i_ready), .o_data(dat3), .o_count(cnt3), .o_stall_cnt(st3));
    pipe_reg_chain #(.SIZE_DATA(8), .DEPTH(4)) u_d4 (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(rdy4),
        .i_data(i_data), .o_valid(vld4), .i_ready(i_ready), .o_data(dat4), .o_count(cnt4), .o_stall_cnt(st4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = 8'h00;
        tick(2);
        i_reset = 1'b0; settle();
        chk("rst_valid", vld2, 0);
        chk("rst_data",  dat2, 0);
        chk("rst_count", cnt2, 0);
        chk("rst_ready", rdy2, 1);
        chk("rst_stall", st4, 0);

        // back-to-back stream through DEPTH=2 with downstream always ready
        i_ready = 1'b1;
        i_valid = 1'b1; i_data = 8'h11; settle();
        chk("bb_rdy0", rdy2, 1);
        tick(); i_data = 8'h22; settle();
        chk("bb_rdy1", rdy2, 1);
        chk("bb_v1",   vld2, 0);
        tick(); i_data = 8'h33; settle();
        chk("bb_rdy2", rdy2, 1);
        chk("bb_v2",   vld2, 1);
        chk("bb_d2",   dat2, 8'h11);
        tick(); i_valid = 1'b0; settle();
        chk("bb_d3",   dat2, 8'h22);
        chk("bb_rdy3", rdy2, 1);
        tick(); settle();
        chk("bb_d4",   dat2, 8'h33);
        tick(); settle();
        chk("bb_empty", vld2, 0);
        tick(3);

        // DEPTH=3 fills while downstream stalls, then resumes
        i_ready = 1'b0;
        i_valid = 1'b1; i_data = 8'hA1; settle();
        chk("fill_rdy0", rdy3, 1);
        tick(); i_data = 8'hA2; settle();
        chk("fill_rdy1", rdy3, 1);
        tick(); i_data = 8'hA3; settle();
        chk("fill_rdy2", rdy3, 1);
        tick(); i_data = 8'hA4; settle();
        chk("full_cnt",  cnt3, 3);
        chk("full_rdy",  rdy3, 0);
        chk("full_d",    dat3, 8'hA1);
        tick(); settle();
        chk("hold_cnt",  cnt3, 3);
        chk("hold_d",    dat3, 8'hA1);
        i_ready = 1'b1; settle();
        chk("thru_rdy",  rdy3, 1);
        tick(); i_valid = 1'b0; settle();
        chk("thru_d",    dat3, 8'hA2);
        chk("thru_cnt",  cnt3, 3);
        tick(); settle();
        chk("drain_d3",  dat3, 8'hA3);
        chk("drain_c3",  cnt3, 2);
        tick(); settle();
        chk("drain_d4",  dat3, 8'hA4);
        tick(); settle();
        chk("drain_v",   vld3, 0);
        chk("drain_c",   cnt3, 0);

        // fresh start; single payload collapses through empty DEPTH=4 stages
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        i_ready = 1'b0; i_valid = 1'b1; i_data = 8'hA5; settle();
        tick(); i_valid = 1'b0; settle();
        chk("bub_rdy1", rdy4, 1);
        tick(2); settle();
        chk("bub_v3",   vld4, 0);
        tick(); settle();
        chk("bub_v4",   vld4, 1);
        chk("bub_d4",   dat4, 8'hA5);
        chk("bub_cnt",  cnt4, 1);
        chk("bub_rdy",  rdy4, 1);

        // ten stall cycles, then flush with downstream ready
        tick(10); settle();
        chk("stall_10", st4, STALL_EXP);
        i_ready = 1'b1; i_flush = 1'b1; settle();
        chk("flush_rdy", rdy4, 0);
        tick(); i_flush = 1'b0; i_ready = 1'b0; settle();
        chk("flush_v4",  vld4, 0);
        chk("flush_st",  st4, STALL_EXP);
        tick(); settle();
        chk("post_st",   st4, STALL_EXP);

        // DEPTH=2 full, flush while offering 0x7E
        i_valid = 1'b1; i_data = 8'h61; settle();
        tick(); i_data = 8'h62; settle();
        tick(); settle();
        chk("f2_cnt",  cnt2, 2);
        chk("f2_rdy",  rdy2, 0);
        i_flush = 1'b1; i_data = 8'h7E; settle();
        tick(); i_flush = 1'b0; i_valid = 1'b0; settle();
        chk("f2_v",    vld2, 0);
        chk("f2_c",    cnt2, 0);
        chk("f2_keep", dat2, 8'h61);
        chk("f2_rdyp", rdy2, 1);
        i_ready = 1'b1;
        tick(); settle();
        chk("f2_nox1", vld2, 0);
        tick(); settle();
        chk("f2_nox2", vld2, 0);

        // reset mid-stream with DEPTH=2 full; reset outranks flush and input
        i_ready = 1'b0; i_valid = 1'b1; i_data = 8'h91; settle();
        tick(); i_data = 8'h92; settle();
        tick(); settle();
        chk("mr_full", cnt2, 2);
        chk("mr_d",    dat2, 8'h91);
        i_reset = 1'b1; i_flush = 1'b1; i_data = 8'h93;
        tick(); i_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0; settle();
        chk("mr_v",    vld2, 0);
        chk("mr_data", dat2, 0);
        chk("mr_cnt",  cnt2, 0);
        chk("mr_rdy",  rdy2, 1);
        chk("mr_st",   st4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8, data payload width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (1..8).
REQ-003 SHALL have port i_clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_flush  input  1  discard all stage contents.
REQ-006 SHALL have port i_valid  input  1  upstream payload valid.
REQ-007 SHALL have port o_ready  output  1  chain can accept upstream payload this cycle.
REQ-008 SHALL have port i_data  input  SIZE_DATA  upstream payload.
REQ-009 SHALL have port o_valid  output  1  last stage holds valid payload.
REQ-010 SHALL have port i_ready  input  1  downstream accepts payload.
REQ-011 SHALL have port o_data  output  SIZE_DATA  last-stage payload.
REQ-012 SHALL have port o_count  output  clog2(DEPTH+1)  number of valid stages.
REQ-013 SHALL have port o_stall_cnt  output  16  downstream stall-cycle counter.

Function
REQ-014 SHALL implement DEPTH stages, each a SIZE_DATA data register plus a valid bit; stage 0 fed by i_data, stage DEPTH-1 drives o_data/o_valid.
REQ-015 SHALL accept input when i_valid && o_ready; SHALL emit output when o_valid && i_ready.
REQ-016 SHALL advance stage k (k = DEPTH-1 first) when it is empty or its content leaves this cycle; stage k then loads stage k-1 data and valid (stage 0 loads i_data, i_valid).
REQ-017 SHALL compute o_ready combinationally = !i_flush && (stage 0 empty || stage 0 advancing); bubbles collapse, so a chain with any empty stage never stalls upstream.
REQ-018 SHALL provide latency of exactly DEPTH cycles from accept to o_valid when i_ready held high, throughput one payload per cycle.
REQ-019 SHALL hold every stage unchanged (data and valid) when it does not advance; a non-advancing stage's data register SHALL NOT load when its predecessor is empty.
REQ-020 SHALL keep the data register of a stage unchanged when its valid bit clears (no data zeroing).
REQ-021 SHALL on i_flush clear all valid bits at the next edge, regardless of i_valid/i_ready; payload presented during flush is not accepted; data registers unchanged.
REQ-022 SHALL with chain full and i_ready low hold all stages and drive o_ready low; simultaneous full and i_ready high SHALL accept and emit in the same cycle.
REQ-023 SHALL drive o_count = popcount of stage valid bits, registered state only (no combinational path from inputs).
REQ-024 SHALL never drop or duplicate a payload; order preserved.

Reset
REQ-025 SHALL on i_reset clear all valid bits and all data registers to 0; o_valid=0, o_data=0, o_count=0, o_stall_cnt=0.
REQ-026 SHALL give i_reset priority over i_flush and all transfers; o_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-027 SHALL, with macro PIPE_REG_CHAIN_STALL_CNT_EN defined, increment o_stall_cnt each cycle o_valid && !i_ready, saturating at 16'hFFFF, cleared only by i_reset (not by i_flush).
REQ-028 SHALL, without PIPE_REG_CHAIN_STALL_CNT_EN, tie o_stall_cnt to 0 and instantiate no counter logic.

Verification
REQ-029 DEPTH=2, i_ready=1, push 0x11,0x22,0x33 back-to-back -> o_data 0x11,0x22,0x33 on cycles 2,3,4 after first accept, o_ready constantly 1.
REQ-030 DEPTH=3, i_ready=0, push 4 payloads -> first 3 accepted, o_count=3, o_ready=0 on 4th; raise i_ready -> 4th accepted same cycle as 1st emitted.
REQ-031 DEPTH=4, one payload 0xA5 then idle, i_ready=0 -> 0xA5 reaches last stage after 4 cycles, o_count=1, o_ready stays 1 (bubble collapse).
REQ-032 DEPTH=2, chain full, i_flush=1 with i_valid=1 data 0x7E -> next cycle o_valid=0, o_count=0, 0x7E never emitted.
REQ-033 Macro defined, o_valid=1, i_ready=0 for 10 cycles, then i_flush -> o_stall_cnt=10 and retained after flush; i_reset -> 0; macro undefined -> always 0.
REQ-034 Reset asserted mid-stream with 2 valid stages -> next cycle o_valid=0, o_data=0, o_count=0, o_ready=1 after release.
